// File: rtl/fb_ahb_writer_if.sv
// rtl/fb_ahb_writer_if.sv - AHB-Lite slave port bundle for the framebuffer writer
interface fb_ahb_writer_if;
  logic        AHB_HSEL;
  logic [11:0] AHB_HADDR;
  logic [1:0]  AHB_HTRANS;
  logic        AHB_HWRITE;
  logic [2:0]  AHB_HSIZE;
  logic [31:0] AHB_HWDATA;
  logic        AHB_HREADY;
  logic        AHB_HREADYOUT;
  logic [31:0] AHB_HRDATA;
  logic        AHB_HRESP;

  modport master (
    output AHB_HSEL, AHB_HADDR, AHB_HTRANS, AHB_HWRITE, AHB_HSIZE, AHB_HWDATA, AHB_HREADY,
    input  AHB_HREADYOUT, AHB_HRDATA, AHB_HRESP
  );

  modport slave (
    input  AHB_HSEL, AHB_HADDR, AHB_HTRANS, AHB_HWRITE, AHB_HSIZE, AHB_HWDATA, AHB_HREADY,
    output AHB_HREADYOUT, AHB_HRDATA, AHB_HRESP
  );
endinterface

// File: rtl/fb_ahb_writer.sv
// rtl/fb_ahb_writer.sv - AHB-Lite framebuffer writer with pixel pointer, XY addressing and fill engine
module fb_ahb_writer #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int ADDR_W    = 15,
  parameter int PIX_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  fb_ahb_writer_if.slave    ahb,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_din,
  output logic              busy
);

  localparam int                FB_SIZE     = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FB_SIZE - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A     = ADDR_W'(FB_WIDTH);
  localparam logic [9:0]        OFF_CTRL    = 10'd0;
  localparam logic [9:0]        OFF_PTR     = 10'd1;
  localparam logic [9:0]        OFF_DATA    = 10'd2;
  localparam logic [9:0]        OFF_FILLCOL = 10'd3;
  localparam logic [9:0]        OFF_XY      = 10'd4;

  typedef enum logic {S_IDLE, S_FILL} state_t;
  state_t state;

  logic              dp_valid;
  logic              dp_write;
  logic [9:0]        dp_addr;
  logic [ADDR_W-1:0] ptr;
  logic [PIX_W-1:0]  fill_col;
  logic              range_err;

  logic              accept;
  logic              data_stall;
  logic              wr_done;
  logic [7:0]        wx;
  logic [7:0]        wy;
  logic              xy_ok;
  logic [ADDR_W-1:0] xy_ptr;
  logic              ptr_ok;
  logic [ADDR_W-1:0] ptr_y;
  logic [ADDR_W-1:0] ptr_x;
  logic [31:0]       xy_word;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign accept      = ahb.AHB_HSEL & ahb.AHB_HTRANS[1] & ahb.AHB_HREADY;
  // A pixel write cannot share the BRAM port with the fill, so it waits for the fill to end
  assign data_stall  = dp_valid & dp_write & (dp_addr == OFF_DATA) & (state == S_FILL);
  assign wr_done     = dp_valid & dp_write & ~data_stall;
  assign busy        = (state == S_FILL);
  assign unused_bits = ^{ahb.AHB_HSIZE, ahb.AHB_HADDR[1:0]};

  assign wx     = ahb.AHB_HWDATA[7:0];
  assign wy     = ahb.AHB_HWDATA[15:8];
  assign xy_ok  = (wx < 8'(FB_WIDTH)) && (wy < 8'(FB_HEIGHT));
  assign xy_ptr = ADDR_W'(wy) * WIDTH_A + ADDR_W'(wx);
  assign ptr_ok = ahb.AHB_HWDATA < 32'(FB_SIZE);

  // Constant divisor, so this folds into fixed logic; x and y each fit in a byte
  assign ptr_y   = ptr / WIDTH_A;
  assign ptr_x   = ptr % WIDTH_A;
  assign xy_word = (32'(ptr_y) << 8) | 32'(ptr_x);

  assign ahb.AHB_HREADYOUT = ~data_stall;
  assign ahb.AHB_HRESP     = 1'b0;
  assign ahb.AHB_HRDATA    = rdata;

  // Read mux driven from the captured data-phase address
  always_comb begin
    rdata = 32'd0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        OFF_CTRL:    rdata = {30'd0, range_err, busy};
        OFF_PTR:     rdata = 32'(ptr);
        OFF_FILLCOL: rdata = 32'(fill_col);
        OFF_XY:      rdata = xy_word;
        default:     rdata = 32'd0;
      endcase
    end
  end

  // Capture the address phase; hold it while the bus is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 10'd0;
    end else if (ahb.AHB_HREADY) begin
      dp_valid <= accept;
      dp_write <= ahb.AHB_HWRITE;
      dp_addr  <= ahb.AHB_HADDR[11:2];
    end
  end

  // Register updates at the edge that completes a write data phase
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      fill_col  <= '0;
      range_err <= 1'b0;
    end else if (wr_done) begin
      case (dp_addr)
        OFF_CTRL: if (ahb.AHB_HWDATA[1]) range_err <= 1'b0;
        OFF_PTR: begin
          if (ptr_ok) ptr <= ahb.AHB_HWDATA[ADDR_W-1:0];
          else        range_err <= 1'b1;
        end
        OFF_DATA:    ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
        OFF_FILLCOL: fill_col <= ahb.AHB_HWDATA[PIX_W-1:0];
        OFF_XY: begin
          if (xy_ok) ptr <= xy_ptr;
          else       range_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fill FSM and registered BRAM write port; fb_addr doubles as the fill counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_din  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          fb_we <= 1'b0;
          if (wr_done && dp_addr == OFF_CTRL && ahb.AHB_HWDATA[0]) begin
            state   <= S_FILL;
            fb_we   <= 1'b1;
            fb_addr <= '0;
            fb_din  <= fill_col;
          end else if (wr_done && dp_addr == OFF_DATA) begin
            fb_we   <= 1'b1;
            fb_addr <= ptr;
            fb_din  <= ahb.AHB_HWDATA[PIX_W-1:0];
          end
        end
        S_FILL: begin
          if (fb_addr == LAST_ADDR) begin
            state <= S_IDLE;
            fb_we <= 1'b0;
          end else begin
            fb_addr <= fb_addr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_ahb_writer.sv
// tb/tb_fb_ahb_writer.sv - scoreboard bench for fb_ahb_writer
module tb_fb_ahb_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_din;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [17:0] fbq[$];
  logic [31:0] rdq[$];
  string       rdnm[$];
  logic        rd_phase = 1'b0;
  int          stalls;

  fb_ahb_writer_if ahb ();

  assign ahb.AHB_HREADY = ahb.AHB_HREADYOUT;

  fb_ahb_writer dut (
    .clk     (clk),
    .reset   (reset),
    .ahb     (ahb.slave),
    .fb_we   (fb_we),
    .fb_addr (fb_addr),
    .fb_din  (fb_din),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: BRAM writes and read data are checked against the queues
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (fbq.size() == 0) begin
        chk("fb_unexpected_write", {14'd0, fb_addr, fb_din}, 32'hFFFF_FFFF);
      end else begin
        chk("fb_write", {14'd0, fb_addr, fb_din}, {14'd0, fbq.pop_front()});
      end
    end
    if (rd_phase && ahb.AHB_HREADYOUT) begin
      if (rdq.size() == 0) chk("rd_unexpected", ahb.AHB_HRDATA, 32'hFFFF_FFFF);
      else                 chk(rdnm.pop_front(), ahb.AHB_HRDATA, rdq.pop_front());
    end
  end

  // Single non-pipelined transfer; called just after a rising edge
  task automatic bus(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input string nm, output int st);
    ahb.AHB_HSEL   = 1'b1;
    ahb.AHB_HTRANS = 2'b10;
    ahb.AHB_HADDR  = a;
    ahb.AHB_HWRITE = wr;
    @(posedge clk); #1;
    ahb.AHB_HSEL   = 1'b0;
    ahb.AHB_HTRANS = 2'b00;
    ahb.AHB_HWDATA = wd;
    if (!wr) begin
      rdq.push_back(exp_rd);
      rdnm.push_back(nm);
      rd_phase = 1'b1;
    end
    st = 0;
    forever begin
      @(negedge clk);
      if (ahb.AHB_HREADYOUT) break;
      st++;
      if (st > 30000) begin
        $display("FAIL bus_timeout: got %0d stall cycles expected fewer than 30000", st);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    rd_phase = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int s;
    bus(1'b1, a, d, 32'd0, "", s);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    int s;
    bus(1'b0, a, 32'd0, exp, nm, s);
  endtask

  // Two pipelined DATA writes with no idle cycle between them
  task automatic data_pair(input logic [31:0] d0, input logic [31:0] d1);
    ahb.AHB_HSEL   = 1'b1;
    ahb.AHB_HTRANS = 2'b10;
    ahb.AHB_HADDR  = 12'h008;
    ahb.AHB_HWRITE = 1'b1;
    @(posedge clk); #1;
    ahb.AHB_HWDATA = d0;
    @(posedge clk); #1;
    ahb.AHB_HSEL   = 1'b0;
    ahb.AHB_HTRANS = 2'b00;
    ahb.AHB_HWDATA = d1;
    @(posedge clk); #1;
  endtask

  task automatic push_fill(input logic [2:0] c);
    for (int i = 0; i < 19200; i++) fbq.push_back({15'(i), c});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (fbq.size() != 0 && n < 25000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, fbq.size(), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    ahb.AHB_HSEL   = 1'b0;
    ahb.AHB_HTRANS = 2'b00;
    ahb.AHB_HADDR  = 12'd0;
    ahb.AHB_HWRITE = 1'b0;
    ahb.AHB_HSIZE  = 3'b010;
    ahb.AHB_HWDATA = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_hreadyout", 32'(ahb.AHB_HREADYOUT), 32'd1);
    chk("rst_hrdata", ahb.AHB_HRDATA, 32'd0);
    chk("rst_hresp", 32'(ahb.AHB_HRESP), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    rd(12'h000, 32'd0, "rst_status");
    rd(12'h004, 32'd0, "rst_ptr");
    rd(12'h00C, 32'd0, "rst_fillcol");

    wr(12'h004, 32'd100);
    fbq.push_back({15'd100, 3'd5});
    fbq.push_back({15'd101, 3'd6});
    data_pair(32'd5, 32'd6);
    rd(12'h004, 32'd102, "ptr_after_pair");

    wr(12'h004, 32'd19199);
    fbq.push_back({15'd19199, 3'd7});
    wr(12'h008, 32'd7);
    fbq.push_back({15'd0, 3'd1});
    wr(12'h008, 32'd1);
    rd(12'h004, 32'd1, "ptr_wrap");
    drain("pixel_writes_done");

    wr(12'h010, 32'h0000_020A);
    rd(12'h004, 32'd330, "xy_ptr");
    rd(12'h010, 32'h0000_020A, "xy_read");
    wr(12'h010, 32'h0000_00A0);
    rd(12'h004, 32'd330, "xy_bad_ptr_kept");
    rd(12'h000, 32'd2, "xy_bad_range_err");
    wr(12'h000, 32'd2);
    rd(12'h000, 32'd0, "range_err_cleared");
    wr(12'h004, 32'd19200);
    rd(12'h004, 32'd330, "ptr_bad_kept");
    rd(12'h000, 32'd2, "ptr_bad_range_err");
    wr(12'h000, 32'd2);
    rd(12'h008, 32'd0, "data_read_zero");
    rd(12'h020, 32'd0, "unmapped_read_zero");

    wr(12'h00C, 32'd3);
    rd(12'h00C, 32'd3, "fillcol");
    push_fill(3'd3);
    wr(12'h000, 32'd1);
    rd(12'h000, 32'd1, "fill_busy");
    repeat (100) @(posedge clk);
    #1;
    wr(12'h000, 32'd1);
    wr(12'h00C, 32'd5);
    rd(12'h00C, 32'd5, "fillcol_mid_fill");
    drain("fill1_done");
    repeat (2) @(posedge clk);
    #1;
    chk("fill1_busy_low", 32'(busy), 32'd0);
    rd(12'h000, 32'd0, "fill1_status");

    push_fill(3'd5);
    wr(12'h000, 32'd1);
    repeat (1000) @(posedge clk);
    #1;
    fbq.push_back({15'd330, 3'd4});
    bus(1'b1, 12'h008, 32'd4, 32'd0, "", stalls);
    chk("data_stall_cycles", stalls, 32'd18199);
    rd(12'h004, 32'd331, "ptr_after_stall");
    drain("fill2_done");

    wr(12'h00C, 32'd2);
    push_fill(3'd2);
    wr(12'h000, 32'd1);
    repeat (499) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_fb_we", 32'(fb_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_written", fbq.size(), 32'd18700);
    fbq.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    rd(12'h000, 32'd0, "post_rst_status");
    rd(12'h004, 32'd0, "post_rst_ptr");
    rd(12'h00C, 32'd0, "post_rst_fillcol");
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
